// File: rtl/sobel_frame_arbiter_pkg.sv
// Shared types for the Sobel frame arbiter: arbiter state and requester count.
package sobel_frame_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_e;
  localparam int N_REQ = 2;
endpackage

// File: rtl/sobel_frame_arbiter_rr_pick2.sv
// Two-way round-robin picker: ptr names the favoured requester when both are eligible.
module rr_pick2
  import sobel_frame_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] eligible,
  input  logic             ptr,
  output logic             grant,
  output logic             valid
);
  assign valid = |eligible;
  assign grant = (&eligible) ? ptr : eligible[1];
endmodule

// File: rtl/sobel_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one Sobel AXI4-Stream input between two cameras.
module sobel_frame_arbiter
  import sobel_frame_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tuser,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tid,
  input  logic [LINE_CNT_W-1:0] img_height,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sof_err,
  output logic [15:0]           drop_cnt
);
  arb_state_e                            state;
  logic                                  grant, ptr, mid_frame;
  logic [LINE_CNT_W-1:0]                 height_q, line_cnt, eff_line;
  logic [N_REQ-1:0]                      s_valid, s_last, s_user, eligible, discard;
  logic [N_REQ-1:0][DATA_WIDTH-1:0]      s_data;
  logic                                  pick, pick_vld, accept, frame_end, sof_mid;
  logic [16:0]                           drop_sum;

  assign s_valid = {s1_axis_tvalid, s0_axis_tvalid};
  assign s_last  = {s1_axis_tlast,  s0_axis_tlast};
  assign s_user  = {s1_axis_tuser,  s0_axis_tuser};
  assign s_data  = {s1_axis_tdata,  s0_axis_tdata};

  // The cycle carrying frame_done is the enforced dead cycle before the next grant.
  assign eligible = (state == IDLE && !frame_done) ? (s_valid & s_user) : '0;
  assign discard  = (state == IDLE) ? (s_valid & ~s_user) : '0;

  rr_pick2 u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (pick),
    .valid    (pick_vld)
  );

  assign busy           = (state == BUSY);
  assign m_axis_tvalid  = busy && s_valid[grant];
  assign m_axis_tdata   = s_data[grant];
  assign m_axis_tlast   = s_last[grant];
  assign m_axis_tuser   = s_user[grant];
  assign m_axis_tid     = grant;
  assign s0_axis_tready = discard[0] | (busy && !grant && m_axis_tready);
  assign s1_axis_tready = discard[1] | (busy &&  grant && m_axis_tready);

  // A tuser beat restarts the frame, so it counts as line 0 for the end-of-frame test.
  assign accept    = m_axis_tvalid && m_axis_tready;
  assign eff_line  = m_axis_tuser ? '0 : line_cnt;
  assign frame_end = accept && m_axis_tlast && (eff_line == height_q - 1'b1);
  assign sof_mid   = accept && m_axis_tuser && ((line_cnt != '0) || mid_frame);
  assign drop_sum  = {1'b0, drop_cnt} + 17'(discard[0]) + 17'(discard[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      ptr        <= 1'b0;
      mid_frame  <= 1'b0;
      height_q   <= LINE_CNT_W'(1);
      line_cnt   <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      case (state)
        IDLE: if (pick_vld) begin
          grant     <= pick;
          height_q  <= (img_height == '0) ? LINE_CNT_W'(1) : img_height;
          line_cnt  <= '0;
          mid_frame <= 1'b0;
          state     <= BUSY;
        end
        BUSY: if (accept) begin
          mid_frame <= 1'b1;
          sof_err   <= sof_mid;
          if (frame_end) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            ptr        <= ~grant;
            line_cnt   <= '0;
          end else if (m_axis_tlast) begin
            line_cnt <= eff_line + 1'b1;
          end else begin
            line_cnt <= eff_line;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_frame_arbiter.sv
// Randomized and directed bench for sobel_frame_arbiter against a frame-level reference model.
module tb_sobel_frame_arbiter;
  localparam int DW = 8;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s0_axis_tvalid = 0, s0_axis_tready, s0_axis_tlast = 0, s0_axis_tuser = 0;
  logic s1_axis_tvalid = 0, s1_axis_tready, s1_axis_tlast = 0, s1_axis_tuser = 0;
  logic [DW-1:0] s0_axis_tdata = 0, s1_axis_tdata = 0, m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready = 1, m_axis_tlast, m_axis_tuser, m_axis_tid;
  logic [LW-1:0] img_height = 1;
  logic busy, frame_done, sof_err;
  logic [15:0] drop_cnt;

  sobel_frame_arbiter #(.DATA_WIDTH(DW), .LINE_CNT_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready), .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready), .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tid(m_axis_tid),
    .img_height(img_height), .busy(busy), .frame_done(frame_done), .sof_err(sof_err),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; bit l; bit u;} beat_t;
  beat_t q0[$], q1[$];
  bit [1:0] cur_v, hs;
  int gap = 0, rdy_mode = 0, rph = 0, rnd_h = 0, cur_h = 1;

  int cyc = 0, n_chk = 0, n_fail = 0;
  // reference model: owner of the filter (-1 = none) plus frame progress
  int own = -1, fav = 0, e_tid = 0, h_m = 1, lines_left = 0, seen = 0, drops = 0;
  bit cool = 0, e_done = 0, e_err = 0;
  int fwd_cnt = 0, done_cnt = 0, err_cnt = 0, last_acc_cyc = 0, done_cyc = 0;
  int first_done = -1, tid1_first = -1;
  logic [7:0] rx_d[$];
  int rx_t[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int src, input logic [7:0] d, input bit l, input bit u);
    beat_t b;
    b.d = d; b.l = l; b.u = u;
    if (src == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic add_frame(input int src, input int h, input int w, input int base);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        push(src, 8'(base + y * w + x), x == w - 1, (y == 0) && (x == 0));
  endtask

  task automatic add_junk(input int src, input int n, input int base);
    for (int i = 0; i < n; i++) push(src, 8'(base + i), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic drive();
    if (!cur_v[0] && q0.size() > 0 && $urandom_range(99) >= gap) cur_v[0] = 1;
    if (!cur_v[1] && q1.size() > 0 && $urandom_range(99) >= gap) cur_v[1] = 1;
    s0_axis_tvalid = cur_v[0];
    s1_axis_tvalid = cur_v[1];
    if (q0.size() > 0) begin
      s0_axis_tdata = q0[0].d; s0_axis_tlast = q0[0].l; s0_axis_tuser = q0[0].u;
    end else begin
      s0_axis_tdata = 0; s0_axis_tlast = 0; s0_axis_tuser = 0;
    end
    if (q1.size() > 0) begin
      s1_axis_tdata = q1[0].d; s1_axis_tlast = q1[0].l; s1_axis_tuser = q1[0].u;
    end else begin
      s1_axis_tdata = 0; s1_axis_tlast = 0; s1_axis_tuser = 0;
    end
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (rph % 4 == 0) || (rph % 4 == 3);
      default: m_axis_tready = ($urandom_range(99) < 70);
    endcase
    rph++;
    // height wobbles only while a frame is owned, where it must be ignored
    if (rnd_h != 0) img_height = (own >= 0) ? LW'($urandom_range(0, 3)) : LW'(cur_h);
  endtask

  task automatic cycle_check();
    bit s0v, s1v, s0u, s1u, mv, bu, bl, el0, el1;
    int exp_drop;
    cyc++;
    if (!rst_n) begin
      own = -1; fav = 0; e_tid = 0; drops = 0; cool = 0; e_done = 0; e_err = 0; hs = 0;
      chk("rst_busy", busy, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_tid", m_axis_tid, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_sof_err", sof_err, 0);
      return;
    end
    s0v = s0_axis_tvalid; s1v = s1_axis_tvalid; s0u = s0_axis_tuser; s1u = s1_axis_tuser;
    mv = (own == 0 && s0v) || (own == 1 && s1v);
    exp_drop = (drops > 65535) ? 65535 : drops;
    chk("busy", busy, own >= 0);
    chk("m_tvalid", m_axis_tvalid, mv);
    chk("m_tid", m_axis_tid, e_tid);
    chk("s0_tready", s0_axis_tready, (own == 0) ? m_axis_tready : (own < 0 && s0v && !s0u));
    chk("s1_tready", s1_axis_tready, (own == 1) ? m_axis_tready : (own < 0 && s1v && !s1u));
    chk("frame_done", frame_done, e_done);
    chk("sof_err", sof_err, e_err);
    chk("drop_cnt", drop_cnt, exp_drop);
    if (mv) begin
      chk("m_tdata", m_axis_tdata, own == 0 ? s0_axis_tdata : s1_axis_tdata);
      chk("m_tlast", m_axis_tlast, own == 0 ? s0_axis_tlast : s1_axis_tlast);
      chk("m_tuser", m_axis_tuser, own == 0 ? s0_axis_tuser : s1_axis_tuser);
    end
    hs = {s1v && s1_axis_tready, s0v && s0_axis_tready};
    if (frame_done) begin
      done_cnt++; done_cyc = cyc;
      if (first_done < 0) first_done = cyc;
    end
    if (sof_err) err_cnt++;
    if (m_axis_tvalid && m_axis_tready) begin
      fwd_cnt++; last_acc_cyc = cyc;
      rx_d.push_back(m_axis_tdata); rx_t.push_back(int'(m_axis_tid));
      if (m_axis_tid && tid1_first < 0) tid1_first = cyc;
    end
    e_done = 0; e_err = 0;
    if (own >= 0) begin
      if (mv && m_axis_tready) begin
        bu = (own == 0) ? s0u : s1u;
        bl = (own == 0) ? s0_axis_tlast : s1_axis_tlast;
        if (bu && seen > 0) e_err = 1;
        if (bu) begin seen = 0; lines_left = h_m; end
        seen++;
        if (bl) lines_left--;
        if (lines_left == 0) begin e_done = 1; fav = 1 - own; own = -1; cool = 1; end
      end
    end else begin
      drops += int'(s0v && !s0u) + int'(s1v && !s1u);
      el0 = s0v && s0u; el1 = s1v && s1u;
      if (cool) cool = 0;
      else if (el0 || el1) begin
        own = (el0 && el1) ? fav : (el0 ? 0 : 1);
        e_tid = own;
        h_m = (img_height == 0) ? 1 : int'(img_height);
        lines_left = h_m; seen = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (hs[0] && q0.size() > 0) begin void'(q0.pop_front()); cur_v[0] = 0; end
    if (hs[1] && q1.size() > 0) begin void'(q1.pop_front()); cur_v[1] = 0; end
    #1 drive();
    @(negedge clk);
    cycle_check();
  endtask

  task automatic do_reset();
    rst_n = 0;
    q0.delete(); q1.delete(); cur_v = 0; hs = 0;
    drive();
    repeat (3) step();
    rst_n = 1;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || own >= 0) && n < budget) begin step(); n++; end
    if (n >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: stream still active after %0d cycles, required idle", budget);
    end
    repeat (3) step();
  endtask

  initial begin
    int k0, f0, d0, e0, nz, h, w;
    do_reset();

    // one height-3, width-4 frame from s0
    img_height = 3; k0 = rx_t.size(); f0 = fwd_cnt; d0 = done_cnt;
    add_frame(0, 3, 4, 8'h00);
    run_idle(200);
    chk("t1_beats", fwd_cnt - f0, 12);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_done_latency", done_cyc - last_acc_cyc, 1);
    nz = 0;
    for (int i = k0; i < rx_t.size(); i++) nz += (rx_t[i] != 0) ? 1 : 0;
    chk("t1_tid_zero", nz, 0);

    // simultaneous SOF after reset: s0 first, s1 two cycles after s0's frame_done
    do_reset();
    img_height = 2; k0 = rx_t.size(); first_done = -1; tid1_first = -1;
    add_frame(0, 2, 3, 8'h40);
    add_frame(1, 2, 3, 8'h80);
    run_idle(200);
    chk("t2_beats", rx_t.size() - k0, 12);
    chk("t2_first_tid", rx_t[k0], 0);
    chk("t2_s0_last_tid", rx_t[k0 + 5], 0);
    chk("t2_s1_first_tid", rx_t[k0 + 6], 1);
    chk("t2_s1_first_data", rx_d[k0 + 6], 8'h80);
    chk("t2_gap", tid1_first - first_done, 2);

    // five pre-SOF beats on s1 are discarded
    do_reset();
    img_height = 1; k0 = rx_d.size(); f0 = fwd_cnt;
    add_junk(1, 5, 8'hE0);
    add_frame(1, 1, 2, 8'h10);
    run_idle(200);
    chk("t3_drop_cnt", drop_cnt, 5);
    chk("t3_beats", fwd_cnt - f0, 2);
    chk("t3_first_data", rx_d[k0], 8'h10);

    // ready pattern 1,0,0,1 across a frame
    rdy_mode = 1; rph = 0; img_height = 2; k0 = rx_d.size(); d0 = done_cnt;
    add_frame(0, 2, 3, 8'h20);
    run_idle(200);
    chk("t4_beats", rx_d.size() - k0, 6);
    for (int i = 0; i < 6; i++) chk("t4_order", rx_d[k0 + i], 8'(8'h20 + i));
    chk("t4_done_count", done_cnt - d0, 1);
    rdy_mode = 0;

    // tuser on the 6th beat of a height-2, width-4 frame
    img_height = 2; f0 = fwd_cnt; d0 = done_cnt; e0 = err_cnt;
    for (int i = 1; i <= 13; i++) push(0, 8'(8'h60 + i), (i == 4) || (i == 9) || (i == 13), (i == 1) || (i == 6));
    run_idle(200);
    chk("t5_sof_err_count", err_cnt - e0, 1);
    chk("t5_done_count", done_cnt - d0, 1);
    chk("t5_beats", fwd_cnt - f0, 13);
    chk("t5_done_latency", done_cyc - last_acc_cyc, 1);

    // reset mid-frame, then requester 0 wins a simultaneous SOF
    img_height = 4;
    add_junk(1, 2, 8'hD0);
    add_frame(0, 4, 3, 8'h90);
    repeat (8) step();
    chk("t6_midframe_busy", busy, 1);
    do_reset();
    chk("t6_busy", busy, 0);
    chk("t6_m_tvalid", m_axis_tvalid, 0);
    chk("t6_drop_cnt", drop_cnt, 0);
    img_height = 1; k0 = rx_t.size();
    add_frame(1, 1, 2, 8'hA0);
    add_frame(0, 1, 2, 8'hB0);
    run_idle(200);
    chk("t6_first_tid", rx_t[k0], 0);
    chk("t6_first_data", rx_d[k0], 8'hB0);

    // randomized traffic: gaps, backpressure, junk, height jitter during frames
    rnd_h = 1;
    for (int b = 0; b < 6; b++) begin
      cur_h = $urandom_range(0, 3);
      h = (cur_h == 0) ? 1 : cur_h;
      gap = $urandom_range(0, 40);
      rdy_mode = 2;
      for (int k = 0; k < 8; k++) begin
        int src;
        src = $urandom_range(0, 1);
        if ($urandom_range(0, 3) == 0) add_junk(src, $urandom_range(1, 2), 8'hC0);
        w = $urandom_range(1, 4);
        add_frame(src, h, w, $urandom_range(0, 255));
      end
      run_idle(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
